reg_dump: RTL and testbench

- Debug read-out sequencer for the picoMIPS 32 x n register file.
- On a start pulse it borrows the register file's rs read port and walks register indices 0..LAST.
- It captures each rs_data value and streams index/value pairs out over a valid/ready handshake, for display or a UART bridge.
- It asserts cpu_hold while active so the CPU does not drive rs or write registers during the dump.

---
 rtl/reg_dump.sv | 91 +++++++++
 tb/tb_reg_dump.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Debug read-out sequencer: walks the register file's rs port and streams (index, value) pairs.
// Optional macro REG_DUMP_SKIP_ZERO_EN starts the walk at %1 instead of %0.
module reg_dump #(
  parameter int n    = 8,
  parameter int LAST = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         cpu_hold,
  output logic [4:0]   rs,
  input  logic [n-1:0] rs_data,
  output logic [4:0]   out_idx,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [4:0] FIRST = 5'd1;
`else
  localparam logic [4:0] FIRST = 5'd0;
`endif
  localparam logic [4:0] LAST_IDX = 5'(LAST);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t     state, next_state;
  logic [4:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    rs         = 5'd0;
    case (state)
      IDLE: begin
        if (start) next_state = READ;
      end
      READ: begin
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        rs         = idx;
        next_state = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        cpu_hold  = 1'b1;
        out_valid = 1'b1;
        // Test for LAST before incrementing so idx can never wrap past 31.
        if (out_ready) next_state = (idx == LAST_IDX) ? DONE : READ;
      end
      DONE: begin
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The register file read is combinational, so the value is captured in the READ cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= 5'd0;
      out_idx  <= 5'd0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) idx <= FIRST;
        READ: begin
          out_data <= rs_data;
          out_idx  <= idx;
        end
        SEND: if (out_ready && idx != LAST_IDX) idx <= idx + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: a LAST=3 instance for the cycle-exact table and corner
// cases, and a LAST=31 instance for the full-range walk.
module tb_reg_dump;

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, ready_a, busy_a, done_a, hold_a, valid_a;
  logic [4:0] rs_a, out_idx_a;
  logic [7:0] rs_data_a, out_data_a;
  logic       start_b, ready_b, busy_b, done_b, hold_b, valid_b;
  logic [4:0] rs_b, out_idx_b;
  logic [7:0] rs_data_b, out_data_b;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  reg_dump #(.n(8), .LAST(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .cpu_hold(hold_a), .rs(rs_a), .rs_data(rs_data_a), .out_idx(out_idx_a),
    .out_data(out_data_a), .out_valid(valid_a), .out_ready(ready_a)
  );

  reg_dump #(.n(8), .LAST(31)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .cpu_hold(hold_b), .rs(rs_b), .rs_data(rs_data_b), .out_idx(out_idx_b),
    .out_data(out_data_b), .out_valid(valid_b), .out_ready(ready_b)
  );

  // Register file models: %0 is hard-wired to zero.
  always_comb begin
    case (rs_a)
      5'd1:    rs_data_a = 8'h11;
      5'd2:    rs_data_a = 8'hA5;
      5'd3:    rs_data_a = 8'hFF;
      default: rs_data_a = 8'h00;
    endcase
  end
  assign rs_data_b = (rs_b == 5'd0) ? 8'h00 : 8'(rs_b) + 8'h40;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [4:0] idx;
    logic [7:0] data;
    logic       busy;
    logic       done;
    int         rs;
  } vec_t;

  vec_t vecs[10];
  int   n_vecs;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_valid_a(input logic [4:0] want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_a && out_idx_a == want) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Follows instance A until it returns to idle, counting accepted pairs and done pulses.
  task automatic drain_a(input int next_idx, output int pairs, output int dones,
                         output bit order_ok, output bit finished);
    pairs    = 0;
    dones    = 0;
    order_ok = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (valid_a && ready_a) begin
        if (int'(out_idx_a) != next_idx) order_ok = 1'b0;
        next_idx++;
        pairs++;
      end
      if (done_a) dones++;
      if (!busy_a) begin
        finished = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, valid_a, 1'b0);
    check({tag, "_busy"},  busy_a,  1'b0);
    check({tag, "_hold"},  hold_a,  1'b0);
    check({tag, "_done"},  done_a,  1'b0);
    check({tag, "_rs"},    rs_a,    5'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         ok, order_ok, finished, rs_ok;
    int         pairs, dones, next_idx;
    logic [4:0] last_idx;
    logic [7:0] last_data;

`ifdef REG_DUMP_SKIP_ZERO_EN
    n_vecs  = 8;
    vecs[0] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 5'd1, 8'h11, 1'b1, 1'b0, -1};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b1, 5'd2, 8'hA5, 1'b1, 1'b0, -1};
    vecs[4] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b1, 5'd3, 8'hFF, 1'b1, 1'b0, -1};
    vecs[6] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, -1};
    vecs[7] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 0};
`else
    n_vecs  = 10;
    vecs[0] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 8'h00, 1'b1, 1'b0, -1};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b1, 1'b1, 5'd1, 8'h11, 1'b1, 1'b0, -1};
    vecs[4] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 2};
    vecs[5] = '{1'b1, 1'b1, 5'd2, 8'hA5, 1'b1, 1'b0, -1};
    vecs[6] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 3};
    vecs[7] = '{1'b1, 1'b1, 5'd3, 8'hFF, 1'b1, 1'b0, -1};
    vecs[8] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, -1};
    vecs[9] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 0};
`endif

    reset   = 1'b1;
    start_a = 1'b0;
    ready_a = 1'b1;
    start_b = 1'b0;
    ready_b = 1'b1;
    #1;
    check_idle_outputs("reset");
    check("reset_out_idx",  out_idx_a,  5'd0);
    check("reset_out_data", out_data_a, 8'h00);
    check("reset_b_busy",   busy_b,     1'b0);
    #11;
    reset = 1'b0;
    step();

    // Basic dump, cycle by cycle from the table.
    pulse_start_a();
    for (int i = 0; i < n_vecs; i++) begin
      ready_a = vecs[i].ready;
      check($sformatf("basic_c%0d_valid", i + 1), valid_a, vecs[i].valid);
      check($sformatf("basic_c%0d_busy", i + 1),  busy_a,  vecs[i].busy);
      check($sformatf("basic_c%0d_hold", i + 1),  hold_a,  vecs[i].busy);
      check($sformatf("basic_c%0d_done", i + 1),  done_a,  vecs[i].done);
      if (vecs[i].valid) begin
        check($sformatf("basic_c%0d_idx", i + 1),  out_idx_a,  vecs[i].idx);
        check($sformatf("basic_c%0d_data", i + 1), out_data_a, vecs[i].data);
      end
      if (vecs[i].rs >= 0)
        check($sformatf("basic_c%0d_rs", i + 1), rs_a, 5'(vecs[i].rs));
      step();
    end

    // Backpressure: hold pair 1 for five cycles.
    ready_a = 1'b1;
    pulse_start_a();
    wait_valid_a(5'd1, ok);
    check("bp_reach_pair1", ok, 1'b1);
    ready_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_hold%0d_valid", c), valid_a,    1'b1);
      check($sformatf("bp_hold%0d_idx", c),   out_idx_a,  5'd1);
      check($sformatf("bp_hold%0d_data", c),  out_data_a, 8'h11);
      check($sformatf("bp_hold%0d_cpu", c),   hold_a,     1'b1);
    end
    ready_a = 1'b1;
    drain_a(1, pairs, dones, order_ok, finished);
    check("bp_finished", finished, 1'b1);
    check("bp_pairs",    pairs,    32'd3);
    check("bp_order",    order_ok, 1'b1);
    check("bp_dones",    dones,    32'd1);

    // start while busy is ignored.
    step();
    pulse_start_a();
    wait_valid_a(5'd1, ok);
    check("swb_reach_pair1", ok, 1'b1);
    pulse_start_a();
    drain_a(2, pairs, dones, order_ok, finished);
    check("swb_finished", finished, 1'b1);
    check("swb_pairs",    pairs,    32'd2);
    check("swb_order",    order_ok, 1'b1);
    check("swb_dones",    dones,    32'd1);
    step();
    check("swb_no_queue", busy_a, 1'b0);

    // Asynchronous reset during SEND of index 2.
    pulse_start_a();
    wait_valid_a(5'd2, ok);
    check("rst_reach_pair2", ok, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_out_idx",  out_idx_a,  5'd0);
    check("rst_mid_out_data", out_data_a, 8'h00);
    #2;
    reset = 1'b0;
    step();
    check("rst_after_busy", busy_a, 1'b0);
    check("rst_after_done", done_a, 1'b0);
    pulse_start_a();
    wait_valid_a(5'(FIRST), ok);
    check("rst_restart_first", ok, 1'b1);
    check("rst_restart_data", out_data_a, (FIRST == 1) ? 8'h11 : 8'h00);
    drain_a(FIRST, pairs, dones, order_ok, finished);
    check("rst_restart_finished", finished, 1'b1);
    check("rst_restart_pairs",    pairs,    32'(4 - FIRST));
    check("rst_restart_dones",    dones,    32'd1);

    // Full range walk on the LAST=31 instance.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    pairs     = 0;
    dones     = 0;
    next_idx  = FIRST;
    order_ok  = 1'b1;
    rs_ok     = 1'b1;
    finished  = 1'b0;
    last_idx  = 5'd0;
    last_data = 8'h00;
    for (int c = 0; c < 120; c++) begin
      if (rs_b > 5'd31 || $isunknown(rs_b)) rs_ok = 1'b0;
      if (valid_b && ready_b) begin
        if (int'(out_idx_b) != next_idx) order_ok = 1'b0;
        if (out_data_b != ((next_idx == 0) ? 8'h00 : 8'(next_idx + 'h40))) order_ok = 1'b0;
        last_idx  = out_idx_b;
        last_data = out_data_b;
        next_idx++;
        pairs++;
      end
      if (done_b) dones++;
      if (!busy_b) begin
        finished = 1'b1;
        break;
      end
      step();
    end
    check("full_finished",  finished,  1'b1);
    check("full_pairs",     pairs,     32'(32 - FIRST));
    check("full_order",     order_ok,  1'b1);
    check("full_last_idx",  last_idx,  5'd31);
    check("full_last_data", last_data, 8'h5F);
    check("full_rs_range",  rs_ok,     1'b1);
    check("full_dones",     dones,     32'd1);
    step();
    check("full_idle_after", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
